prog_loader: RTL
================

Name: prog_loader

Overview:
- Hardware program loader for the riscv32s subset CPU.
- Receives a byte stream containing a program image and writes the 32-bit instruction words into instruction ROM through its write port.
- Holds the core in reset until the image is loaded and its checksum passes.
- Publishes the program length in words, which is used for halt detection when `pc>>2 >= prog_len`.

Parameters:
- ROMDEPTH, 1024, instruction memory depth in words.
- ADDRW, $clog2(ROMDEPTH), word-address width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a byte this cycle.
- start  input  1  single-cycle pulse: abort or finish, then begin a new load.
- mem_we  output  1  ROM write enable, one-cycle pulse per word.
- mem_addr  output  ADDRW  ROM word address.
- mem_wdata  output  32  ROM write data.
- core_hold  output  1  reset request to the core, high = hold.
- prog_len  output  ADDRW+1  number of words loaded.
- done  output  1  load complete, checksum OK.
- error  output  1  load failed.

Behaviour:
- Image format, all fields little-endian 32-bit:
  - header word N (word count),
  - N data words,
  - checksum word = sum of the data words mod 2^32.
- States: HDR, DATA, CSUM, DONE, ERR.
- Reset values: state HDR; byte counter 0; word counter 0; sum 0; mem_we 0; mem_addr 0; mem_wdata 0; core_hold 1; prog_len 0; done 0; error 0.
- s_ready = 1 in HDR, DATA and CSUM; 0 in DONE and ERR. It is decoded combinationally from the state and is 0 while reset is high.
- A byte is accepted on a rising edge with s_valid && s_ready.
  - Bytes are shifted in LSB first (byte k fills bits 8k+7:8k).
  - A 2-bit byte counter wraps 3 -> 0 on each completed word.
  - s_valid may drop at any time. Gaps have no effect other than delay.
- HDR, word completes:
  - N > ROMDEPTH -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
  - prog_len is not updated here.
- DATA, word W (index i) completes:
  - On the next cycle: mem_we=1, mem_addr=i, mem_wdata=W for exactly one cycle.
  - sum += W (32-bit wrap).
  - Word counter increments; after word N-1 -> CSUM.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- CSUM, word completes:
  - Equal to sum -> DONE, prog_len <= N.
  - Otherwise -> ERR.
  - done or error is registered high on the cycle after the last checksum byte is accepted.
- DONE: done=1, core_hold=0.
- ERR: error=1, core_hold=1.
- core_hold = 1 in every state except DONE.
- start pulse, in any state:
  - Next state HDR.
  - Byte counter, word counter and sum cleared.
  - done=0, error=0, core_hold=1, prog_len=0.
  - Any write scheduled for that cycle still completes.
  - Takes priority over byte acceptance in the same cycle: that byte is dropped.
- reset overrides start. Reset mid-load discards all partial state; already-written ROM words are not cleared.
- Load latency, full stream with no gaps: 4·(N+2) accept cycles plus 1 cycle to done.

Test Plan:
- Valid load:
  - Stimulus: N=3, words 0x00000013, 0x00100093, 0xFFF00113, checksum 0x000001B9.
  - Response: mem_we pulses at addr 0,1,2 with those data; done=1; error=0; prog_len=3; core_hold=0; s_ready=0.
- Bad checksum:
  - Stimulus: same image, checksum 0x000001BA.
  - Response: three writes occur; then error=1, done=0, core_hold=1, prog_len=0, s_ready=0.
- Oversize header:
  - Stimulus: N=ROMDEPTH+1 (1025).
  - Response: error=1 one cycle after the 4th header byte; no mem_we pulses; trailing bytes are not accepted.
- Stalled stream:
  - Stimulus: first image with s_valid low on every other cycle and random gaps up to 5 cycles.
  - Response: identical writes and final outputs to the valid-load case.
- Abort and reload:
  - Stimulus: start pulse after data word 0 and 2 bytes of word 1, then a fresh N=1 image (0x00000013, checksum 0x00000013).
  - Response: a single write of 0x00000013 at addr 0 from the new image; done=1; prog_len=1.
- Empty image:
  - Stimulus: N=0, checksum 0.
  - Response: no writes; done=1; prog_len=0; core_hold=0.
- Reset mid-DATA:
  - Response: all outputs return to reset values on the next edge and s_ready=1 in HDR.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: parses a little-endian {N, data[N], checksum} byte stream,
// writes each data word into instruction ROM and releases the core once the checksum matches.
module prog_loader #(
    parameter int ROMDEPTH = 1024,
    parameter int ADDRW    = $clog2(ROMDEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             start,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_hold,
    output logic [ADDRW:0]   prog_len,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [ADDRW:0] CNT_ONE = (ADDRW+1)'(1);

    state_t           state_q, state_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [ADDRW:0]   wcnt_q, wcnt_d;
    logic [ADDRW:0]   n_q, n_d;
    logic [31:0]      sum_q, sum_d;
    logic             we_q, we_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [ADDRW:0]   plen_q, plen_d;

    logic             accept;
    logic [31:0]      word;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        wcnt_d  = wcnt_q;
        n_d     = n_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        plen_d  = plen_q;

        s_ready = !reset && (state_q == HDR || state_q == DATA || state_q == CSUM);
        accept  = s_valid && s_ready;
        word    = {s_data, shift_q};

        if (start) begin
            // A byte offered in the start cycle is deliberately dropped.
            state_d = HDR;
            bcnt_d  = '0;
            wcnt_d  = '0;
            sum_d   = '0;
            plen_d  = '0;
        end else if (accept) begin
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q != 2'd3) begin
                shift_d[{bcnt_q, 3'b000} +: 8] = s_data;
            end else begin
                unique case (state_q)
                    HDR: begin
                        n_d = word[ADDRW:0];
                        if (word > 32'(ROMDEPTH))  state_d = ERR;
                        else if (word == '0)        state_d = CSUM;
                        else                        state_d = DATA;
                    end
                    DATA: begin
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[ADDRW-1:0];
                        wdata_d = word;
                        sum_d   = sum_q + word;
                        wcnt_d  = wcnt_q + CNT_ONE;
                        if (wcnt_q + CNT_ONE == n_q) state_d = CSUM;
                    end
                    CSUM: begin
                        if (word == sum_q) begin
                            state_d = DONE;
                            plen_d  = n_q;
                        end else begin
                            state_d = ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HDR;
            bcnt_q  <= '0;
            shift_q <= '0;
            wcnt_q  <= '0;
            n_q     <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            plen_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            wcnt_q  <= wcnt_d;
            n_q     <= n_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            plen_q  <= plen_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign prog_len  = plen_q;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign core_hold = (state_q != DONE);

endmodule
